// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sample FIFO family.
//   DEF_DATA_SIZE / DEF_ADDR_SIZE : default parameter values
//   DEPTH(addr_size)              : number of words for a given address width
//   LEVEL_W(addr_size)            : width of pointers and fill level
package fifo_pkg;

  localparam int unsigned DEF_DATA_SIZE = 12;
  localparam int unsigned DEF_ADDR_SIZE = 8;

  function automatic int unsigned DEPTH(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // One extra bit over the address distinguishes full from empty.
  function automatic int unsigned LEVEL_W(input int unsigned addr_size);
    return addr_size + 32'd1;
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port RAM for the sample FIFO.
//   clk, rst_n       : clock, asynchronous active-low reset (read register only)
//   w_en/w_addr/w_data : synchronous write port
//   r_en/r_addr      : read request; r_data is registered (1-cycle latency)
//   r_data           : read data, holds its value while r_en is low
module sample_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_en,
  input  logic [ADDR_SIZE-1:0] w_addr,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 r_en,
  input  logic [ADDR_SIZE-1:0] r_addr,
  output logic [DATA_SIZE-1:0] r_data
);

  logic [DATA_SIZE-1:0] mem [0:DEPTH(ADDR_SIZE)-1];

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_data <= '0;
    else if (r_en) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with exact fill level, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a registered read port with a valid strobe.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   w_inc_i, w_data_i      : write request and data
//   r_inc_i                : read request
//   r_data_o, r_valid_o    : registered read data and its one-cycle strobe
//   flush_i                : synchronous clear of pointers (contents kept)
//   clr_flags_i            : clears sticky overflow/underflow
//   af_thresh_i/ae_thresh_i: almost-full (level >=) / almost-empty (level <=)
//   full_o, empty_o, almost_full_o, almost_empty_o, level_o : status
//   overflow_o, underflow_o: sticky error flags
module sample_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 w_inc_i,
  input  logic [DATA_SIZE-1:0] w_data_i,
  input  logic                 r_inc_i,
  output logic [DATA_SIZE-1:0] r_data_o,
  output logic                 r_valid_o,
  input  logic                 flush_i,
  input  logic                 clr_flags_i,
  input  logic [ADDR_SIZE:0]   af_thresh_i,
  input  logic [ADDR_SIZE:0]   ae_thresh_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int unsigned     LW      = LEVEL_W(ADDR_SIZE);
  localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH(ADDR_SIZE));

  logic [LW-1:0] w_ptr, r_ptr, level;
  logic          w_acc, r_acc;

  // Modular difference of the extended pointers is the exact fill level.
  assign level          = w_ptr - r_ptr;
  assign level_o        = level;
  assign full_o         = (level == DEPTH_L);
  assign empty_o        = (level == '0);
  assign almost_full_o  = (level >= af_thresh_i);
  assign almost_empty_o = (level <= ae_thresh_i);

  // Flush suppresses both accepts, so it also suppresses memory access.
  assign w_acc = w_inc_i & ~full_o  & ~flush_i;
  assign r_acc = r_inc_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else if (flush_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (w_acc) w_ptr <= w_ptr + LW'(1);
      if (r_acc) r_ptr <= r_ptr + LW'(1);
    end
  end

  // Set term is OR-ed last so a coincident error wins over clr_flags_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      r_valid_o   <= 1'b0;
    end else begin
      overflow_o  <= (overflow_o  & ~clr_flags_i) | (w_inc_i & full_o  & ~flush_i);
      underflow_o <= (underflow_o & ~clr_flags_i) | (r_inc_i & empty_o & ~flush_i);
      r_valid_o   <= r_acc;
    end
  end

  sample_fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .w_en   (w_acc),
    .w_addr (w_ptr[ADDR_SIZE-1:0]),
    .w_data (w_data_i),
    .r_en   (r_acc),
    .r_addr (r_ptr[ADDR_SIZE-1:0]),
    .r_data (r_data_o)
  );

endmodule
